// File: rtl/allophone_fifo.sv
// Allophone FIFO feeding the Speech256 core: buffers host-written 6-bit codes and strobes them out on ldq.
// Optional synchronous flush input is enabled by defining ALLO_FIFO_FLUSH_EN.
module allophone_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_an,
`ifdef ALLO_FIFO_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic [5:0]            wr_data,
  input  logic                  wr_stb,
  input  logic                  ovf_clr,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  busy,
  input  logic                  ldq,
  output logic [5:0]            data_out,
  output logic                  data_stb
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_LOW
  } state_t;

  state_t                state;
  logic [5:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  flush_req;
  logic                  pop;
  logic                  wr_acc;
  logic                  wr_drop;

`ifdef ALLO_FIFO_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign full  = (level == LEVEL_FULL);
  assign empty = (level == '0);
  assign busy  = !empty || !ldq || (state != IDLE);

  // Full is judged on the pre-edge level, so a same-edge pop never rescues a write.
  assign pop     = (state == IDLE) && ldq && !empty && !flush_req;
  assign wr_acc  = wr_stb && !full && !flush_req;
  assign wr_drop = wr_stb && full && !flush_req;

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_req) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, pop})
        2'b10:   level <= level + LEVEL_ONE;
        2'b01:   level <= level - LEVEL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an)
      overflow <= 1'b0;
    else if (wr_drop)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  // WAIT_LOW blocks a second load until the core has dropped ldq.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state    <= IDLE;
      data_out <= 6'h00;
      data_stb <= 1'b0;
    end else if (flush_req) begin
      state    <= IDLE;
      data_stb <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_stb <= 1'b0;
          if (pop) begin
            data_out <= mem[rd_ptr];
            data_stb <= 1'b1;
            state    <= STROBE;
          end
        end
        STROBE: begin
          data_stb <= 1'b0;
          state    <= WAIT_LOW;
        end
        WAIT_LOW: begin
          data_stb <= 1'b0;
          if (!ldq)
            state <= IDLE;
        end
        default: begin
          data_stb <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_allophone_fifo.sv
// Directed self-checking bench for allophone_fifo; flush steps run when ALLO_FIFO_FLUSH_EN is defined.
module tb_allophone_fifo;

  logic       clk = 1'b0;
  logic       rst_an;
  logic [5:0] wr_data;
  logic       wr_stb;
  logic       ovf_clr;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       busy;
  logic       ldq;
  logic [5:0] data_out;
  logic       data_stb;
`ifdef ALLO_FIFO_FLUSH_EN
  logic       flush;
`endif

  int checks = 0;
  int failures = 0;
  int strobes;
  logic [5:0] exp_q [4];

  allophone_fifo #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rst_an   (rst_an),
`ifdef ALLO_FIFO_FLUSH_EN
    .flush    (flush),
`endif
    .wr_data  (wr_data),
    .wr_stb   (wr_stb),
    .ovf_clr  (ovf_clr),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .busy     (busy),
    .ldq      (ldq),
    .data_out (data_out),
    .data_stb (data_stb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One accepted-or-dropped write per call.
  task automatic applyStimulus(input logic [5:0] code);
    wr_data = code;
    wr_stb  = 1'b1;
    tick();
    wr_stb  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_an = 1'b1; wr_data = 6'h00; wr_stb = 1'b0; ovf_clr = 1'b0; ldq = 1'b0;
`ifdef ALLO_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    #3 rst_an = 1'b0;
    tick(); tick();
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_data_out", 32'(data_out), 32'h00);
    checkOutput("rst_data_stb", 32'(data_stb), 0);
    checkOutput("rst_busy", 32'(busy), 1);
    rst_an = 1'b1;
    tick();

    $display("[TB] single word latency");
    ldq = 1'b1;
    #1 checkOutput("idle_busy", 32'(busy), 0);
    applyStimulus(6'h2A);
    checkOutput("lat_level1", 32'(level), 1);
    checkOutput("lat_stb_early", 32'(data_stb), 0);
    tick();
    checkOutput("lat_stb", 32'(data_stb), 1);
    checkOutput("lat_data", 32'(data_out), 32'h2A);
    checkOutput("lat_level0", 32'(level), 0);
    tick();
    checkOutput("lat_stb_one_cycle", 32'(data_stb), 0);
    checkOutput("wait_low_busy", 32'(busy), 1);
    ldq = 1'b0;
    tick();
    ldq = 1'b1;
    #1 checkOutput("busy_clear", 32'(busy), 0);
    ldq = 1'b0;
    tick();

    $display("[TB] fill and overflow");
    for (int i = 0; i < 16; i++) applyStimulus(6'(i));
    checkOutput("fill_level", 32'(level), 16);
    checkOutput("fill_full", 32'(full), 1);
    checkOutput("fill_empty", 32'(empty), 0);
    applyStimulus(6'h3E);
    checkOutput("ovf_set", 32'(overflow), 1);
    checkOutput("ovf_level", 32'(level), 16);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checkOutput("ovf_clr", 32'(overflow), 0);
    ovf_clr = 1'b1; wr_stb = 1'b1; tick(); wr_stb = 1'b0;
    checkOutput("ovf_set_wins", 32'(overflow), 1);
    tick(); ovf_clr = 1'b0;
    checkOutput("ovf_clr2", 32'(overflow), 0);

    $display("[TB] write and pop while full");
    ldq = 1'b1; wr_data = 6'h3E; wr_stb = 1'b1;
    tick();
    wr_stb = 1'b0;
    checkOutput("fullpop_stb", 32'(data_stb), 1);
    checkOutput("fullpop_data", 32'(data_out), 32'h00);
    checkOutput("fullpop_level", 32'(level), 15);
    checkOutput("fullpop_ovf", 32'(overflow), 1);
    for (int i = 1; i < 16; i++) begin
      ldq = 1'b0; tick(); tick();
      ldq = 1'b1; tick();
      checkOutput($sformatf("drain_stb%0d", i), 32'(data_stb), 1);
      checkOutput($sformatf("drain_data%0d", i), 32'(data_out), 32'(i));
    end
    checkOutput("drain_empty", 32'(empty), 1);
    ldq = 1'b0; tick(); tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

    $display("[TB] write and pop at level 4, ldq held high");
    for (int i = 0; i < 4; i++) applyStimulus(6'h11 + 6'(i));
    checkOutput("lvl4_level", 32'(level), 4);
    ldq = 1'b1; wr_data = 6'h15; wr_stb = 1'b1;
    tick();
    wr_stb = 1'b0;
    checkOutput("lvl4_same_level", 32'(level), 4);
    checkOutput("lvl4_stb", 32'(data_stb), 1);
    checkOutput("lvl4_data", 32'(data_out), 32'h11);
    strobes = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_stb) strobes++;
    end
    checkOutput("hold_no_strobe", 32'(strobes), 0);
    checkOutput("hold_level", 32'(level), 4);
    checkOutput("hold_data", 32'(data_out), 32'h11);
    exp_q[0] = 6'h12; exp_q[1] = 6'h13; exp_q[2] = 6'h14; exp_q[3] = 6'h15;
    for (int i = 0; i < 4; i++) begin
      ldq = 1'b0; tick(); tick();
      ldq = 1'b1; tick();
      checkOutput($sformatf("order_data%0d", i), 32'(data_out), 32'(exp_q[i]));
    end
    ldq = 1'b0; tick(); tick();

    $display("[TB] three ldq handshakes");
    applyStimulus(6'h05); applyStimulus(6'h10); applyStimulus(6'h3F);
    exp_q[0] = 6'h05; exp_q[1] = 6'h10; exp_q[2] = 6'h3F;
    for (int i = 0; i < 3; i++) begin
      ldq = 1'b1; tick();
      checkOutput($sformatf("hs_stb%0d", i), 32'(data_stb), 1);
      checkOutput($sformatf("hs_data%0d", i), 32'(data_out), 32'(exp_q[i]));
      tick();
      checkOutput($sformatf("hs_stb_low_a%0d", i), 32'(data_stb), 0);
      tick();
      checkOutput($sformatf("hs_stb_low_b%0d", i), 32'(data_stb), 0);
      ldq = 1'b0; tick();
    end
    checkOutput("hs_empty", 32'(empty), 1);
    checkOutput("hs_data_hold", 32'(data_out), 32'h3F);

    $display("[TB] reset during strobe");
    for (int i = 0; i < 6; i++) applyStimulus(6'h20 + 6'(i));
    ldq = 1'b1; tick();
    checkOutput("mid_stb", 32'(data_stb), 1);
    checkOutput("mid_level", 32'(level), 5);
    #1 rst_an = 1'b0;
    #1;
    checkOutput("mid_rst_stb", 32'(data_stb), 0);
    checkOutput("mid_rst_level", 32'(level), 0);
    checkOutput("mid_rst_empty", 32'(empty), 1);
    checkOutput("mid_rst_data", 32'(data_out), 32'h00);
    ldq = 1'b0;
    tick();
    rst_an = 1'b1;
    tick();

`ifdef ALLO_FIFO_FLUSH_EN
    $display("[TB] flush");
    for (int i = 0; i < 7; i++) applyStimulus(6'h30 + 6'(i));
    checkOutput("flush_pre_level", 32'(level), 7);
    flush = 1'b1; ldq = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_level", 32'(level), 0);
    checkOutput("flush_stb", 32'(data_stb), 0);
    checkOutput("flush_empty", 32'(empty), 1);
    tick();
    checkOutput("flush_no_late_stb", 32'(data_stb), 0);
    ldq = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
